v74x163_wide: RTL

V74X163_WIDE -- requirements
Module: v74x163_wide

---
 rtl/v74x163_wide.sv | 76 +++++++
 1 files changed

// File: rtl/v74x163_wide.sv
// Parameterised synchronous up/down counter in the style of a 74x163, with a
// programmable terminal count, wrap pulse and sticky out-of-range-load flag.
module v74x163_wide #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load_n,
    input  logic             enp,
    input  logic             ent,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rco,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    // Priority below clear: load, then count (both enables), else hold.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        err_d   = err_q;
        if (!load_n) begin
            if (d > MAX_COUNT) begin
                count_d = MAX_COUNT;
                err_d   = 1'b1;
            end else begin
                count_d = d;
            end
        end else if (enp && ent) begin
            if (up) begin
                if (count_q == MAX_COUNT) begin
                    count_d = ZERO;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (count_q == ZERO) begin
                    count_d = MAX_COUNT;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_q <= ZERO;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    // Carry out ignores enp so a cascade can gate on the upstream stage's T path.
    assign rco      = ent & ((up & (count_q == MAX_COUNT)) | (~up & (count_q == ZERO)));
    assign q        = count_q;
    assign wrap     = wrap_q;
    assign load_err = err_q;

endmodule
